// File: rtl/dino_pkg.sv
// Shared constants for the Dino game controller: button channel indices and
// the default debounce / long-hold timings for a 50 MHz clock.
package dino_pkg;

   localparam int KEY_CLR     = 0;
   localparam int KEY_RESTART = 1;
   localparam int KEY_DEBUG   = 2;
   localparam int KEY_JUMP    = 3;

   localparam int N_KEYS_DEFAULT       = 4;
   localparam int DEBOUNCE_CYCLES_50M  = 500000;
   localparam int LONG_CYCLES_50M      = 50000000;
   localparam int DEBOUNCE_CYCLES_SIM  = 8;
   localparam int LONG_CYCLES_SIM      = 32;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter, hold counter
// and registered press / release / long-hold pulses.
module key_debounce_ch
   import dino_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
   parameter int CNT_W           = 21,
   parameter int LONG_CYCLES     = LONG_CYCLES_50M,
   parameter int LONG_W          = 26
) (
   input  logic clk,
   input  logic clr,
   input  logic key_raw,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
   localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CYCLES);
   localparam logic [LONG_W-1:0] HOLD_ONE = LONG_W'(1'b1);

   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              level_q, level_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LONG_W-1:0] hold_q, hold_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;

   // Next-state logic for synchroniser, debounce, hold counter and pulses.
   always_comb begin
      sync1_d   = key_raw;
      sync2_d   = sync1_q;
      level_d   = level_q;
      cnt_d     = {CNT_W{1'b0}};
      hold_d    = {LONG_W{1'b0}};

      // A return to the accepted level at any point restarts the count.
      if (sync2_q == level_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         level_d = ~level_q;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (!level_q) begin
         hold_d = {LONG_W{1'b0}};
      end else if (hold_q == HOLD_MAX) begin
         hold_d = hold_q;
      end else begin
         hold_d = hold_q + HOLD_ONE;
      end

      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
      long_d    = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
   end

   // State registers, cleared asynchronously by clr.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         hold_q    <= {LONG_W{1'b0}};
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Button-conditioning stage: N_KEYS independent debounce channels plus a
// combined any_press strobe for the game controller.
module key_debounce
   import dino_pkg::*;
#(
   parameter int N_KEYS          = N_KEYS_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
   parameter int CNT_W           = 21,
   parameter int LONG_CYCLES     = LONG_CYCLES_50M,
   parameter int LONG_W          = 26
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic              any_press
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W),
         .LONG_CYCLES    (LONG_CYCLES),
         .LONG_W         (LONG_W)
      ) u_ch (
         .clk          (clk),
         .clr          (clr),
         .key_raw      (key_raw[i]),
         .key_level    (key_level[i]),
         .press_pulse  (press_pulse[i]),
         .release_pulse(release_pulse[i]),
         .long_pulse   (long_pulse[i])
      );
   end

   // Taken straight from the pulse registers so it adds no latency.
   assign any_press = |press_pulse;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with short simulation timings; a
// sliding-window reference model predicts every output on every cycle.
module tb_key_debounce;
   import dino_pkg::*;

   localparam int NK = 4;
   localparam int D  = DEBOUNCE_CYCLES_SIM;
   localparam int L  = LONG_CYCLES_SIM;

   logic          clk = 1'b0;
   logic          clr;
   logic [NK-1:0] key_raw;
   logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse;
   logic          any_press;

   int errors = 0;
   int checks = 0;

   key_debounce #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_W(21), .LONG_CYCLES(L), .LONG_W(26)
   ) dut (
      .clk(clk), .clr(clr), .key_raw(key_raw), .key_level(key_level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .any_press(any_press)
   );

   always #5 clk = ~clk;

   // Reference model: s[n] is key_raw at edge n. A level flips at edge n when
   // the D samples s[n-2]..s[n-1-D] all differ from the current level.
   bit [NK-1:0] hist[$];
   bit [NK-1:0] m_level, m_press, m_rel, m_long;
   int          rise_n[NK];
   int          n = 0;

   function automatic bit [NK-1:0] past(int d);
      int idx = hist.size() - 1 - d;
      if (idx < 0) return '0;
      return hist[idx];
   endfunction

   task automatic model_reset();
      hist.delete();
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NK; i++) rise_n[i] = -1000000;
   endtask

   task automatic model_edge();
      bit [NK-1:0] nl, tmp;
      hist.push_back(key_raw);
      if (hist.size() > 64) void'(hist.pop_front());
      for (int i = 0; i < NK; i++) begin
         bit tog = 1'b1;
         for (int d = 2; d <= D + 1; d++) begin
            tmp = past(d);
            if (tmp[i] == m_level[i]) tog = 1'b0;
         end
         m_long[i]  = (rise_n[i] == n - L);
         m_press[i] = tog & ~m_level[i];
         m_rel[i]   = tog & m_level[i];
         nl[i]      = m_level[i] ^ tog;
         if (m_press[i]) rise_n[i] = n;
         if (m_rel[i])   rise_n[i] = -1000000;
      end
      m_level = nl;
      n++;
   endtask

   function automatic logic [4*NK:0] exp_vec();
      return {m_level, m_press, m_rel, m_long, |m_press};
   endfunction

   function automatic logic [4*NK:0] dut_vec();
      return {key_level, press_pulse, release_pulse, long_pulse, any_press};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (clr) model_reset(); else model_edge();
      #1;
   endtask

   task automatic settle(input string name);
      key_raw = '0;
      for (int t = 0; t < D + 6; t++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL %s_settle t=%0d got=%h exp=%h", name, t, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; key_raw = '0; model_reset();
      for (int t = 0; t < 3; t++) tick();
      checks++;
      if (dut_vec() !== 17'h0_0000) begin
         errors++;
         $display("FAIL reset_state got=%h exp=0", dut_vec());
      end
      clr = 1'b0;
      settle("reset");
   endtask

   task automatic test_clean_press();
      int first = -1, cnt = 0;
      key_raw = 4'b1000;
      for (int t = 0; t < 16; t++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clean_press t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
         end
         if (press_pulse[KEY_JUMP] && any_press) begin
            cnt++;
            if (first < 0) first = t;
         end
      end
      checks++;
      if (first !== 9 || cnt !== 1) begin
         errors++;
         $display("FAIL clean_press_edge got=%0d/%0d exp=9/1", first, cnt);
      end
      settle("clean_press");
   endtask

   task automatic test_bounce(input int last_high, input int exp_presses);
      int seg_len[4];
      bit seg_val[4];
      int presses = 0, early_high = 0;
      seg_len = '{5, 2, last_high, D + 6};
      seg_val = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t < seg_len[s]; t++) begin
            key_raw = {2'b00, seg_val[s], 1'b0};
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL bounce_%0d s=%0d t=%0d got=%h exp=%h", last_high, s, t, dut_vec(), exp_vec());
            end
            if (press_pulse[KEY_RESTART]) presses++;
            if (s < 2 && key_level[KEY_RESTART]) early_high++;
         end
      end
      checks++;
      if (presses !== exp_presses || early_high !== 0) begin
         errors++;
         $display("FAIL bounce_count_%0d got=%0d/%0d exp=%0d/0", last_high, presses, early_high, exp_presses);
      end
      settle("bounce");
   endtask

   task automatic test_long_hold();
      int p = -1, lp = -1, lcnt = 0, r = -1;
      for (int t = 0; t < 50 + D + 8; t++) begin
         key_raw = (t < 50) ? 4'b0100 : 4'b0000;
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL long_hold t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
         end
         if (press_pulse[KEY_DEBUG] && p < 0) p = t;
         if (long_pulse[KEY_DEBUG]) begin lcnt++; lp = t; end
         if (release_pulse[KEY_DEBUG] && r < 0) r = t;
      end
      checks++;
      if (p !== 9 || lp !== 9 + L || lcnt !== 1 || r !== 50 + D + 1) begin
         errors++;
         $display("FAIL long_hold_timing got=%0d/%0d/%0d/%0d exp=9/%0d/1/%0d",
                  p, lp, lcnt, r, 9 + L, 50 + D + 1);
      end
      settle("long_hold");
   endtask

   task automatic test_simultaneous();
      int first = -1, any_cnt = 0;
      key_raw = 4'b1001;
      for (int t = 0; t < 14; t++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL simultaneous t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
         end
         if (any_press) any_cnt++;
         if (press_pulse === 4'b1001 && first < 0) first = t;
      end
      checks++;
      if (first !== 9 || any_cnt !== 1) begin
         errors++;
         $display("FAIL simultaneous_edge got=%0d/%0d exp=9/1", first, any_cnt);
      end
      settle("simultaneous");
   endtask

   task automatic test_reset_mid();
      int first = -1;
      key_raw = 4'b1000;
      for (int t = 0; t < 12; t++) tick();
      clr = 1'b1; model_reset();
      #1;
      checks++;
      if (dut_vec() !== 17'h0_0000) begin
         errors++;
         $display("FAIL reset_mid_clear got=%h exp=0", dut_vec());
      end
      for (int t = 0; t < 3; t++) tick();
      clr = 1'b0;
      for (int t = 1; t <= 14; t++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
         end
         if (press_pulse[KEY_JUMP] && first < 0) first = t;
      end
      checks++;
      if (first !== D + 2) begin
         errors++;
         $display("FAIL reset_mid_edge got=%0d exp=%0d", first, D + 2);
      end
      settle("reset_mid");
   endtask

   task automatic test_boundary(input int steady, input int exp_presses);
      int presses = 0;
      for (int t = 0; t < steady + D + 6; t++) begin
         key_raw = (t < steady) ? 4'b0001 : 4'b0000;
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL boundary_%0d t=%0d got=%h exp=%h", steady, t, dut_vec(), exp_vec());
         end
         if (press_pulse[KEY_CLR]) presses++;
      end
      checks++;
      if (presses !== exp_presses) begin
         errors++;
         $display("FAIL boundary_count_%0d got=%0d exp=%0d", steady, presses, exp_presses);
      end
      settle("boundary");
   endtask

   task automatic test_random();
      int rates[4];
      int rate;
      rates = '{2, 6, 20, 60};
      for (int blk = 0; blk < 8; blk++) begin
         rate = rates[$urandom_range(0, 3)];
         for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < NK; i++)
               if ($urandom_range(0, rate - 1) == 0) key_raw[i] = ~key_raw[i];
            if ($urandom_range(0, 299) == 0) begin
               clr = 1'b1; model_reset();
               tick(); tick();
               clr = 1'b0;
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL random blk=%0d t=%0d got=%h exp=%h", blk, t, dut_vec(), exp_vec());
            end
         end
      end
      settle("random");
   endtask

   initial begin
      clr = 1'b1;
      key_raw = '0;
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce(7, 0);
      test_bounce(12, 1);
      test_long_hold();
      test_simultaneous();
      test_reset_mid();
      test_boundary(D - 1, 0);
      test_boundary(D, 1);
      test_boundary(D + 3, 1);
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
